// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are accepted in IDLE, one sum bit is
// produced per clock LSB-first in RUN, and the result is held in DONE.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.
// Latency: OUT_VALID rises WIDTH rising edges after the accepting edge.
// Backpressure: the result is held indefinitely while OUT_READY=0; no new
// operands are taken until the result has been drained (IN_READY=1 only in IDLE).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // operand A shift register
    logic [WIDTH-1:0] b_q, b_d;        // operand B (or ~B) shift register
    logic [WIDTH-1:0] sum_q, sum_d;    // result, filled from the MSB end
    logic             c_q, c_d;        // running carry between bit slices
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;    // index of the bit being produced

    // One full-adder slice built from two half adders and an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c;
    logic fa_s, fa_c;

    // Operand preparation at acceptance: subtraction is A + ~B + 1, so the
    // carry flop is preset instead of adding a separate increment.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full-adder slice on the current LSBs of the operand shift registers.
    always_comb begin
        ha1_s = a_q[0] ^ b_q[0];
        ha1_c = a_q[0] & b_q[0];
        ha2_s = ha1_s ^ c_q;
        ha2_c = ha1_s & c_q;
        fa_s  = ha2_s;
        fa_c  = ha1_c | ha2_c;
    end

    // Select the B operand and initial carry for add or subtract.
    always_comb begin
        b_load = B;
        c_load = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if (SUB) begin
            b_load = ~B;
            c_load = 1'b1;
        end
`endif
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = b_load;
                    c_d     = c_load;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    carry_d = fa_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // SUM/CARRY are simply held; only the handshake moves us on.
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are pure decodes of the registered state.
    always_comb begin
        IN_READY  = (state_q == IDLE);
        OUT_VALID = (state_q == DONE);
        SUM       = sum_q;
        CARRY     = carry_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8: fixed vector table,
// hand-written reset/backpressure sequences and randomized operations
// compared against a plain-arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, carry;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int vectors     = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB       (sub),
`endif
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .SUM       (sum),
        .CARRY     (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        int           stall;
        bit           toggle;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the whole word is added (or subtracted) in one step.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
        int unsigned r;
        if (msub) r = int'(ma) + ((1 << W) - int'(mb));
        else      r = int'(ma) + int'(mb);
        return r[W:0];
    endfunction

    // Run one operation from IDLE through drain, checking latency, result,
    // hold under backpressure and return to IDLE.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input int stall, input bit toggle, input logic [W:0] exp,
                          input string tag);
        int edges;
        chk({tag, "_rdy_idle"}, in_ready, 1);
        a = ia;
        b = ib;
`ifdef SERIAL_ADDER_SUB_EN
        sub = isub;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_rdy_run"}, in_ready, 0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (toggle) begin
                in_valid = $urandom_range(0, 1);
                a = W'($urandom);
                b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
                sub = $urandom_range(0, 1);
`endif
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, edges, W);
        chk({tag, "_sum"}, sum, exp[W-1:0]);
        chk({tag, "_carry"}, carry, exp[W]);
        chk({tag, "_rdy_done"}, in_ready, 0);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, out_valid, 1);
            chk({tag, "_hold_sum"}, sum, exp[W-1:0]);
            chk({tag, "_hold_carry"}, carry, exp[W]);
            chk({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain_rdy"}, in_ready, 1);
        chk({tag, "_drain_vld"}, out_valid, 0);
        chk({tag, "_drain_sum"}, sum, exp[W-1:0]);
        chk({tag, "_drain_carry"}, carry, exp[W]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   seen;

        tbl.push_back('{8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'hA5, 8'h5A, 1'b0, 5, 1'b0, 8'hFF, 1'b0});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 1, 1'b1, 8'h80, 1'b0});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 0, 1'b1, 8'h00, 1'b1});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 2, 1'b0, 8'hFE, 1'b1});
        tbl.push_back('{8'h3C, 8'h0F, 1'b0, 0, 1'b0, 8'h4B, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{8'h05, 8'h07, 1'b1, 0, 1'b0, 8'hFE, 1'b0});
        tbl.push_back('{8'h07, 8'h05, 1'b1, 1, 1'b0, 8'h02, 1'b1});
        tbl.push_back('{8'h42, 8'h42, 1'b1, 0, 1'b1, 8'h00, 1'b1});
        sub = 1'b0;
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed table, first entry accepted on the first edge after reset.
        foreach (tbl[i])
            run_op(tbl[i].va, tbl[i].vb, tbl[i].vsub, tbl[i].stall, tbl[i].toggle,
                   {tbl[i].exp_carry, tbl[i].exp_sum}, $sformatf("tbl%0d", i));

        // Idle with IN_VALID low: nothing must start.
        a = 8'h12; b = 8'h34;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_stays_rdy", in_ready, 1);
        chk("idle_no_vld", out_valid, 0);

        // Reset three edges into RUN aborts with no result.
        a = 8'h7F; b = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_run_rdy", in_ready, 1);
        chk("abort_run_vld", out_valid, 0);
        chk("abort_run_sum", sum, 0);
        chk("abort_run_carry", carry, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_run_no_result", seen, 0);

        // Reset while a result is waiting in DONE, then accept immediately.
        a = 8'hC3; b = 8'h81; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        chk("done_reached", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_done_vld", out_valid, 0);
        chk("abort_done_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 0, 1'b0, 9'h003, "post_rst");

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = $urandom_range(0, 1);
`endif
            run_op(ra, rb, rs, $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                   model(ra, rb, rs), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
